vec_mem_burst: RTL and testbench

- Parametrised wide vector memory for the solver datapath (p/r/x vector storage). Each row holds NO_OF_UNITS elements of ELEMENT_WIDTH bits.
- Successor to the single-row, combinational-read vector store. Adds per-unit write masking, registered 1-cycle reads, synchronous reset of control state, and a burst-read engine.
- The burst engine streams LEN consecutive rows to the processing units with a valid/ready handshake, then pulses finish.

---
 rtl/vec_mem_pkg.sv | 19 +
 rtl/vec_mem_array.sv | 56 +++++
 rtl/vec_mem_burst.sv | 123 ++++++++++++
 tb/tb_vec_mem_burst.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and default widths for the solver vector memory and its clients.
package vec_mem_pkg;

  localparam int unsigned NO_OF_UNITS_D   = 8;
  localparam int unsigned ELEMENT_WIDTH_D = 64;
  localparam int unsigned DEPTH_D         = 1024;
  localparam int unsigned ADDR_WIDTH_D    = 10;
  localparam int unsigned LEN_WIDTH_D     = 11;
  localparam int unsigned ROW_WIDTH_D     = NO_OF_UNITS_D * ELEMENT_WIDTH_D;

  typedef logic [ROW_WIDTH_D-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vec_mem_array.sv
// Row RAM with per-element write mask, one registered read port and
// write-first forwarding when the read hits the row being written.
module vec_mem_array
  import vec_mem_pkg::*;
#(
  parameter int unsigned NO_OF_UNITS   = NO_OF_UNITS_D,
  parameter int unsigned ELEMENT_WIDTH = ELEMENT_WIDTH_D,
  parameter int unsigned DEPTH         = DEPTH_D,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_D,
  parameter              INIT_FILE     = ""
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [NO_OF_UNITS-1:0]               wr_mask,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] wr_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data
);

  localparam int unsigned ROW_W = NO_OF_UNITS * ELEMENT_WIDTH;

  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] rd_row_c;

  // Stored row, overridden by any element being written to the same row this cycle.
  always_comb begin
    rd_row_c = mem[rd_addr];
    for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
      if (wr_en && wr_mask[i] && (wr_addr == rd_addr)) begin
        rd_row_c[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
        if (wr_mask[i]) begin
          mem[wr_addr][i*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= wr_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_row_c;
    end
  end

endmodule

// File: rtl/vec_mem_burst.sv
// Vector memory with single-row reads and a valid/ready burst-read engine
// that streams consecutive rows (wrapping at DEPTH) and pulses finish.
module vec_mem_burst
  import vec_mem_pkg::*;
#(
  parameter int unsigned NO_OF_UNITS   = NO_OF_UNITS_D,
  parameter int unsigned ELEMENT_WIDTH = ELEMENT_WIDTH_D,
  parameter int unsigned DEPTH         = DEPTH_D,
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_D,
  parameter int unsigned LEN_WIDTH     = LEN_WIDTH_D,
  parameter              INIT_FILE     = ""
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [NO_OF_UNITS-1:0]               wr_mask,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] wr_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] rd_data,
  output logic                                 rd_valid,
  input  logic                                 burst_start,
  input  logic [ADDR_WIDTH-1:0]                burst_base,
  input  logic [LEN_WIDTH-1:0]                 burst_len,
  input  logic                                 burst_ready,
  output logic                                 burst_valid,
  output logic                                 burst_last,
  output logic                                 busy,
  output logic                                 finish
);

  state_e                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [LEN_WIDTH-1:0]  remaining, remaining_n;
  logic                  valid_n, last_n;
  logic                  issue_c, single_c;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    remaining_n = remaining;
    valid_n     = burst_valid;
    last_n      = burst_last;
    issue_c     = 1'b0;
    single_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (burst_start) begin
          ptr_n       = burst_base;
          remaining_n = burst_len;
          state_n     = (burst_len == '0) ? ST_DONE : ST_RUN;
        end else begin
          single_c = rd_en;
        end
      end
      ST_RUN: begin
        // A fresh read may replace the current beat only when that beat is leaving.
        if ((remaining != '0) && (!burst_valid || burst_ready)) begin
          issue_c     = 1'b1;
          ptr_n       = ptr + ADDR_WIDTH'(1);
          remaining_n = remaining - LEN_WIDTH'(1);
          valid_n     = 1'b1;
          last_n      = (remaining == LEN_WIDTH'(1));
        end else if (burst_valid && burst_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          if (burst_last) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign ram_rd_en   = issue_c | single_c;
  assign ram_rd_addr = issue_c ? ptr : rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      remaining   <= '0;
      burst_valid <= 1'b0;
      burst_last  <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      remaining   <= remaining_n;
      burst_valid <= valid_n;
      burst_last  <= last_n;
      rd_valid    <= single_c;
      busy        <= (state_n == ST_RUN);
      finish      <= (state_n == ST_DONE);
    end
  end

  vec_mem_array #(
    .NO_OF_UNITS  (NO_OF_UNITS),
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .INIT_FILE    (INIT_FILE)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_mask(wr_mask),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (ram_rd_en),
    .rd_addr(ram_rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_vec_mem_burst.sv
// Directed bench for vec_mem_burst: single reads, masked write-first,
// bursts with wrap and back-pressure, zero length, ignored start, reset abort.
module tb_vec_mem_burst;
  import vec_mem_pkg::*;

  localparam int unsigned NU = 8;
  localparam int unsigned EW = 64;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [NU-1:0] wr_mask = '0;
  logic [AW-1:0] wr_addr = '0;
  row_t          wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  row_t          rd_data;
  logic          rd_valid;
  logic          burst_start = 1'b0;
  logic [AW-1:0] burst_base = '0;
  logic [LW-1:0] burst_len = '0;
  logic          burst_ready = 1'b0;
  logic          burst_valid, burst_last, busy, finish;

  row_t model [DP];
  int   n_chk = 0;
  int   n_err = 0;

  vec_mem_burst #(
    .NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .DEPTH(DP), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .burst_start(burst_start), .burst_base(burst_base),
    .burst_len(burst_len), .burst_ready(burst_ready), .burst_valid(burst_valid),
    .burst_last(burst_last), .busy(busy), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic row_t pat(input int k);
    return {NU{64'(k)}};
  endfunction

  task automatic write_row(input logic [AW-1:0] a, input logic [NU-1:0] m, input row_t d);
    wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    for (int i = 0; i < NU; i++)
      if (m[i]) model[a][i*EW +: EW] = d[i*EW +: EW];
    tick;
    wr_en = 1'b0;
  endtask

  initial begin
    row_t held;
    logic hold_pending;
    int   beat;
    bit   seen_fin;

    for (int i = 0; i < DP; i++) model[i] = '0;

    // Reset state
    rst = 1'b1; tick; tick; rst = 1'b0;
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_bvalid", burst_valid, 1'b0);

    for (int k = 0; k < 5; k++) write_row(AW'(k), 8'hFF, pat(k));
    write_row(4'd5, 8'hFF, '1);

    // Single read of row 2
    rd_en = 1'b1; rd_addr = 4'd2; tick; rd_en = 1'b0;
    check("rd2_valid", rd_valid, 1'b1);
    check("rd2_data", rd_data, pat(2));
    tick;
    check("rd2_valid_drop", rd_valid, 1'b0);
    check("rd2_data_hold", rd_data, pat(2));

    // Masked write with same-cycle read of the same row
    rd_en = 1'b1; rd_addr = 4'd5;
    write_row(4'd5, 8'b0000_0001, pat(5));
    rd_en = 1'b0;
    check("wf_valid", rd_valid, 1'b1);
    check("wf_data", rd_data, {{7{64'hFFFF_FFFF_FFFF_FFFF}}, 64'd5});
    rd_en = 1'b1; tick; rd_en = 1'b0;
    check("mask_stored", rd_data, {{7{64'hFFFF_FFFF_FFFF_FFFF}}, 64'd5});

    // Burst base 2 len 4, ready held high; a stray start and rd_en mid-burst are ignored
    burst_ready = 1'b1; burst_base = 4'd2; burst_len = 5'd4; burst_start = 1'b1;
    tick; burst_start = 1'b0;
    check("b1_busy", busy, 1'b1);
    check("b1_valid0", burst_valid, 1'b0);
    tick;
    check("b1_beat0", rd_data, model[2]);
    check("b1_valid", burst_valid, 1'b1);
    check("b1_last0", burst_last, 1'b0);
    burst_start = 1'b1; burst_base = 4'd9; burst_len = 5'd1; rd_en = 1'b1; rd_addr = 4'd0;
    tick; burst_start = 1'b0; rd_en = 1'b0;
    check("b1_beat1", rd_data, model[3]);
    check("b1_no_rdvalid", rd_valid, 1'b0);
    tick;
    check("b1_beat2", rd_data, model[4]);
    check("b1_last2", burst_last, 1'b0);
    tick;
    check("b1_beat3", rd_data, model[5]);
    check("b1_last3", burst_last, 1'b1);
    check("b1_valid3", burst_valid, 1'b1);
    tick;
    check("b1_valid_end", burst_valid, 1'b0);
    check("b1_finish", finish, 1'b1);
    check("b1_busy_end", busy, 1'b0);
    tick;
    check("b1_finish_pulse", finish, 1'b0);

    // Wrapping burst with ready pattern 1,0,0,1,0,0,...
    write_row(4'd14, 8'hFF, pat(14));
    write_row(4'd15, 8'hFF, pat(15));
    burst_base = 4'd14; burst_len = 5'd4; burst_start = 1'b1; burst_ready = 1'b0;
    tick; burst_start = 1'b0;
    beat = 0; seen_fin = 1'b0;
    for (int c = 0; c < 40 && !seen_fin; c++) begin
      burst_ready = (c % 3 == 0);
      if (burst_valid && burst_ready) begin
        check("wrap_data", rd_data, model[(14 + beat) % DP]);
        check("wrap_last", burst_last, (beat == 3));
        beat++;
      end
      held = rd_data;
      hold_pending = burst_valid && !burst_ready;
      tick;
      if (hold_pending) begin
        check("wrap_hold_data", rd_data, held);
        check("wrap_hold_valid", burst_valid, 1'b1);
      end
      if (finish) seen_fin = 1'b1;
    end
    check("wrap_beats", 512'(beat), 512'd4);
    check("wrap_finish_seen", seen_fin, 1'b1);
    burst_ready = 1'b1;
    tick;

    // Zero-length burst
    burst_base = 4'd3; burst_len = 5'd0; burst_start = 1'b1;
    tick; burst_start = 1'b0;
    check("z_finish", finish, 1'b1);
    check("z_valid", burst_valid, 1'b0);
    check("z_busy", busy, 1'b0);
    tick;
    check("z_finish_pulse", finish, 1'b0);
    check("z_valid_after", burst_valid, 1'b0);

    // Reset after two beats of a six-row burst
    burst_base = 4'd0; burst_len = 5'd6; burst_start = 1'b1;
    tick; burst_start = 1'b0;
    tick;
    check("ra_beat0", rd_data, model[0]);
    tick;
    check("ra_beat1", rd_data, model[1]);
    rst = 1'b1; tick; rst = 1'b0;
    check("ra_valid", burst_valid, 1'b0);
    check("ra_busy", busy, 1'b0);
    check("ra_finish", finish, 1'b0);
    check("ra_rd_data", rd_data, '0);
    rd_en = 1'b1; rd_addr = 4'd1; tick; rd_en = 1'b0;
    check("ra_idle_read", rd_valid, 1'b1);
    check("ra_idle_data", rd_data, model[1]);
    tick;
    check("ra_no_finish", finish, 1'b0);
    burst_base = 4'd3; burst_len = 5'd2; burst_start = 1'b1;
    tick; burst_start = 1'b0;
    tick;
    check("nb_beat0", rd_data, model[3]);
    check("nb_last0", burst_last, 1'b0);
    tick;
    check("nb_beat1", rd_data, model[4]);
    check("nb_last1", burst_last, 1'b1);
    tick;
    check("nb_finish", finish, 1'b1);
    check("nb_valid_end", burst_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
